// File: rtl/calc_display_driver.sv
// calc_display_driver: shows a 32-bit binary result in decimal on a multiplexed
// common-anode 7-segment display. A double-dabble engine does one shift per clk.
// Latency: 34 cycles from capture to display register (busy for 33). No backpressure:
//   value changes during a conversion are picked up by the following IDLE compare.
// Ports: clk, reset (sync, active-high), value[31:0] in; seg[6:0] {g..a} active-low,
//   an[DIGITS-1:0] one-hot active-low (bit 0 = rightmost), dp (const 1), busy, overflow out.
// Optional build macro: SIGNED_DISPLAY_EN (two's-complement value with minus sign).
`timescale 1ns/1ps
module calc_display_driver #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       value,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              dp,
  output logic              busy,
  output logic              overflow
);

  localparam int NIB = 10;                 // 32-bit unsigned needs 10 decimal digits
  localparam int PW  = $clog2(SCAN_DIV);
  localparam int IW  = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_UPDATE} state_t;

  state_t            state_q;
  logic              pending_q;
  logic [31:0]       last_q;
  logic [31:0]       sr_q;
  logic [4*NIB-1:0]  bcd_q;
  logic [4*NIB-1:0]  disp_q;
  logic [4:0]        cnt_q;
  logic [NIB-1:0]    blank_q;
  logic [NIB-1:0]    minus_q;
  logic              ovf_q;
  logic              busy_q;
  logic [PW-1:0]     presc_q;
  logic [IW-1:0]     idx_q;
  logic [6:0]        seg_q;
  logic [DIGITS-1:0] an_q;
`ifdef SIGNED_DISPLAY_EN
  logic              neg_q;
`endif

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'b1000000;
      4'd1:    dec7 = 7'b1111001;
      4'd2:    dec7 = 7'b0100100;
      4'd3:    dec7 = 7'b0110000;
      4'd4:    dec7 = 7'b0011001;
      4'd5:    dec7 = 7'b0010010;
      4'd6:    dec7 = 7'b0000010;
      4'd7:    dec7 = 7'b1111000;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0010000;
      default: dec7 = SEG_BLANK;
    endcase
  endfunction

  // Magnitude captured into the shift register.
  logic [31:0] mag_d;
  always_comb begin
`ifdef SIGNED_DISPLAY_EN
    mag_d = value[31] ? (~value + 32'd1) : value;
`else
    mag_d = value;
`endif
  end

  // One double-dabble step: add-3 correction, then shift {bcd, sr} left.
  logic [4*NIB-1:0] bcd_adj;
  logic [4*NIB-1:0] bcd_d;
  logic [31:0]      sr_d;
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NIB; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {bcd_d, sr_d} = {bcd_adj, sr_q} << 1;
  end

  // Display attributes derived from the finished BCD word (used in UPDATE).
  logic [NIB-1:0] nz;
  logic [NIB-1:0] blank_d;
  logic [NIB-1:0] minus_d;
  logic           ovf_d;
  logic           seen;
`ifdef SIGNED_DISPLAY_EN
  logic           placed;
`endif
  always_comb begin
    nz      = '0;
    blank_d = '0;
    minus_d = '0;
    ovf_d   = 1'b0;
    seen    = 1'b0;
    for (int i = 0; i < NIB; i++) nz[i] = |bcd_q[4*i +: 4];
    // A digit is blank when it and everything above it is zero.
    for (int i = NIB - 1; i >= 0; i--) begin
      seen       = seen | nz[i];
      blank_d[i] = ~seen;
    end
    blank_d[0] = 1'b0;
    for (int i = 0; i < NIB; i++) begin
      if (i >= DIGITS && nz[i]) ovf_d = 1'b1;
    end
`ifdef SIGNED_DISPLAY_EN
    // Minus goes in the lowest blank digit; no room on the display means overflow.
    placed = 1'b0;
    if (neg_q) begin
      for (int i = 1; i < DIGITS; i++) begin
        if (blank_d[i] && !blank_d[i-1]) begin
          minus_d[i] = 1'b1;
          placed     = 1'b1;
        end
      end
      if (!placed) ovf_d = 1'b1;
    end
`endif
  end

  // Scan prescaler and digit index.
  logic          tc;
  logic [PW-1:0] presc_d;
  logic [IW-1:0] idx_d;
  always_comb begin
    tc      = (presc_q == PW'(SCAN_DIV - 1));
    presc_d = tc ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (tc) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
  end

  // seg is decoded from the next index so it lands in the same cycle as an.
  logic [3:0]        nib_sel;
  logic              blank_sel;
  logic              minus_sel;
  logic [6:0]        seg_d;
  logic [DIGITS-1:0] an_d;
  always_comb begin
    nib_sel   = '0;
    blank_sel = 1'b1;
    minus_sel = 1'b0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_d == IW'(i)) begin
        nib_sel   = disp_q[4*i +: 4];
        blank_sel = blank_q[i];
        minus_sel = minus_q[i];
      end
    end
    if (ovf_q)          seg_d = (idx_d == '0) ? SEG_E : SEG_BLANK;
    else if (minus_sel) seg_d = SEG_MINUS;
    else if (blank_sel) seg_d = SEG_BLANK;
    else                seg_d = dec7(nib_sel);
    an_d = ~(DIGITS'(1) << idx_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b1;
      last_q    <= '0;
      sr_q      <= '0;
      bcd_q     <= '0;
      disp_q    <= '0;
      cnt_q     <= '0;
      blank_q   <= {{(NIB-1){1'b1}}, 1'b0};
      minus_q   <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      presc_q   <= '0;
      idx_q     <= '0;
      seg_q     <= SEG_BLANK;
      an_q      <= '1;
`ifdef SIGNED_DISPLAY_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      case (state_q)
        S_IDLE: begin
          if (pending_q || value != last_q) begin
            sr_q      <= mag_d;
            last_q    <= value;
            bcd_q     <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_SHIFT;
`ifdef SIGNED_DISPLAY_EN
            neg_q     <= value[31];
`endif
          end
        end
        S_SHIFT: begin
          bcd_q <= bcd_d;
          sr_q  <= sr_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= S_UPDATE;
        end
        S_UPDATE: begin
          disp_q  <= bcd_q;
          blank_q <= blank_d;
          minus_q <= minus_d;
          ovf_q   <= ovf_d;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign dp       = 1'b1;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule
